grant_xfer_mux: RTL and testbench
=================================

# grant_xfer_mux

Transfer stage directly downstream of the 4-port round-robin arbiter. It takes the arbiter's one-hot grant and captures the granted requester's data word. It presents that word to a single shared sink over a valid/ready handshake, then returns a one-cycle acknowledge to the winning requester so it can drop its request. Multi-hot grants are rejected and flagged.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; must match the arbiter grant width.
- `DW`, 8: data word width per requester.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `gnt`  in  NREQ  one-hot grant from the arbiter; all-zero means no grant.
- `req_data`  in  NREQ*DW  packed requester words; port i occupies `[i*DW +: DW]`.
- `req_ack`  out  NREQ  one-cycle pulse to the requester whose word the sink accepted.
- `m_valid`  out  1  word valid towards the sink.
- `m_data`  out  DW  captured word.
- `m_src`  out  $clog2(NREQ)  index of the source port of `m_data`.
- `m_ready`  in  1  sink ready.
- `busy`  out  1  high in any state other than IDLE.
- `gnt_err`  out  1  one-cycle pulse when a multi-hot grant is sampled in IDLE.

## Operation
- FSM states: IDLE, SEND, ACK.
- IDLE
  - If `gnt` is exactly one-hot at a rising edge, capture `req_data[idx]` into `m_data` and `idx` into `m_src`, then go to SEND.
  - If `gnt` is zero, stay in IDLE.
  - If `gnt` is multi-hot, stay in IDLE, capture nothing, and pulse `gnt_err` in the next cycle.
- SEND
  - `m_valid`=1, with `m_data` and `m_src` held stable.
  - On an edge with `m_ready`=1, the handshake completes and the FSM goes to ACK.
  - Otherwise stay in SEND indefinitely; there is no timeout.
- ACK
  - `m_valid`=0 and `req_ack[m_src]`=1 for exactly this cycle.
  - Unconditionally return to IDLE.
- `gnt` is ignored outside IDLE. Grant changes during SEND or ACK have no effect.
- `m_valid` never deasserts before the handshake completes, except on reset.
- All outputs are registered.
- Reset values: state IDLE; `m_valid`=0, `m_data`=0, `m_src`=0, `req_ack`=0, `busy`=0, `gnt_err`=0.
- Reset mid-transfer: at the reset edge, `m_valid` drops and the captured word is discarded. No `req_ack` is issued for it. The requester re-requests.

## Timing
- One-hot grant sampled at edge k: `m_valid`=1 from edge k+1.
- Sink ready already high: handshake at edge k+2, `req_ack` high during cycle k+2..k+3, IDLE at edge k+3.
- Minimum transfer period is 3 cycles. A back-to-back grant can be captured at edge k+3.
- `gnt_err` rises at the edge after the bad sample and lasts 1 cycle.
- `busy` tracks state with zero extra latency: high exactly when state is not IDLE.

## Configuration
- Macro: `GRANT_XFER_STATS_EN`.
- When defined, the following are added:
  - One 16-bit saturating counter per port, incremented at that port's ACK cycle; it holds at 16'hFFFF.
  - A 16-bit saturating `err_cnt` for multi-hot grants.
  - Ports `stat_sel` (in, $clog2(NREQ)), `stat_cnt` (out, 16, registered, 1-cycle read latency) and `err_cnt` (out, 16).
  - `rst` clears all counters.
- When undefined: the counters, their ports and their logic are absent; all other behaviour is identical.

## Structure
- Package `grant_xfer_pkg`:
  - state enum (IDLE=2'd0, SEND=2'd1, ACK=2'd2);
  - `NREQ_DEF`, `DW_DEF`;
  - `STAT_W`=16.
- Sub-module `onehot_to_index`: combinational. Takes `gnt` and returns `idx`, `any` (nonzero) and `multi` (more than one bit set). The FSM consumes these three signals only.

## Test plan
- `gnt`=4'b0100, `req_data` port2=8'hA5, `m_ready`=1 → `m_valid` from k+1, `m_data`=8'hA5, `m_src`=2; `req_ack`=4'b0100 for one cycle at k+2; `busy` low at k+3.
- `m_ready`=0 for 5 cycles after capture, `gnt` toggling during the wait → `m_data` and `m_src` stable throughout, no second capture, `req_ack` only after `m_ready` rises.
- `gnt`=4'b0011 in IDLE → `gnt_err` pulses 1 cycle, `m_valid` stays 0, state stays IDLE.
- `rst`=1 while in SEND → all outputs return to reset values next edge, no `req_ack`; the following `gnt`=4'b0001 transfers normally.
- Round-robin grant sequence 0001, 0010, 0100, 1000 with sink always ready → four transfers with `m_src` 0, 1, 2, 3 at a 3-cycle period.
- With `GRANT_XFER_STATS_EN` defined, 70000 acks on port 1 → `stat_cnt` for `stat_sel`=1 reads 16'hFFFF; the other ports read 0.

Source files
------------

// File: rtl/grant_xfer_mux_pkg.sv
// Shared types and defaults for the grant transfer stage.
package grant_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 8;
  localparam int STAT_W   = 16;

endpackage

// File: rtl/grant_xfer_mux_if.sv
// Grant/data/ack and sink handshake bundle; master is the transfer stage side.
interface grant_xfer_mux_if
  import grant_xfer_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    gnt;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ack;
  logic               m_valid;
  logic [DW-1:0]      m_data;
  logic [IW-1:0]      m_src;
  logic               m_ready;
  logic               busy;
  logic               gnt_err;

  modport master (
    input  gnt, req_data, m_ready,
    output req_ack, m_valid, m_data, m_src, busy, gnt_err
  );

  modport slave (
    output gnt, req_data, m_ready,
    input  req_ack, m_valid, m_data, m_src, busy, gnt_err
  );

endinterface

// File: rtl/grant_xfer_mux_onehot_to_index.sv
// Decodes a grant vector into a binary index plus "any" and "more than one" flags.
module onehot_to_index
  import grant_xfer_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any,
  output logic            multi
);

  always_comb begin
    idx   = '0;
    any   = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        if (any) multi = 1'b1;
        any = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/grant_xfer_mux.sv
// Captures the granted requester's word, hands it to the sink, then acks the requester.
// Optional per-port ack and bad-grant counters are enabled by defining GRANT_XFER_STATS_EN.
module grant_xfer_mux
  import grant_xfer_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
) (
  input logic clk,
  input logic rst,
  grant_xfer_mux_if.master bus
`ifdef GRANT_XFER_STATS_EN
  ,
  input  logic [$clog2(NREQ)-1:0] stat_sel,
  output logic [STAT_W-1:0]       stat_cnt,
  output logic [STAT_W-1:0]       err_cnt
`endif
);

  localparam int IW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic            m_valid_q, m_valid_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic [IW-1:0]   m_src_q, m_src_d;
  logic [NREQ-1:0] req_ack_q, req_ack_d;
  logic            busy_q, busy_d;
  logic            gnt_err_q, gnt_err_d;

  logic [IW-1:0]   oh_idx;
  logic            oh_any;
  logic            oh_multi;

  onehot_to_index #(.NREQ(NREQ), .IW(IW)) u_onehot (
    .gnt   (bus.gnt),
    .idx   (oh_idx),
    .any   (oh_any),
    .multi (oh_multi)
  );

  // Outputs are derived from the next state so every one of them leaves a flop.
  always_comb begin
    state_d   = state_q;
    m_data_d  = m_data_q;
    m_src_d   = m_src_q;
    req_ack_d = '0;
    gnt_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (oh_multi) begin
          gnt_err_d = 1'b1;
        end else if (oh_any) begin
          state_d  = SEND;
          m_data_d = bus.req_data[oh_idx*DW +: DW];
          m_src_d  = oh_idx;
        end
      end
      SEND: begin
        if (bus.m_ready) begin
          state_d            = ACK;
          req_ack_d[m_src_q] = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    m_valid_d = (state_d == SEND);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_src_q   <= '0;
      req_ack_q <= '0;
      busy_q    <= 1'b0;
      gnt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_src_q   <= m_src_d;
      req_ack_q <= req_ack_d;
      busy_q    <= busy_d;
      gnt_err_q <= gnt_err_d;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_src   = m_src_q;
  assign bus.req_ack = req_ack_q;
  assign bus.busy    = busy_q;
  assign bus.gnt_err = gnt_err_q;

`ifdef GRANT_XFER_STATS_EN
  logic [STAT_W-1:0] ack_cnt_q [NREQ];
  logic [STAT_W-1:0] ack_cnt_d [NREQ];
  logic [STAT_W-1:0] err_cnt_q, err_cnt_d;
  logic [STAT_W-1:0] stat_cnt_q, stat_cnt_d;

  // Counters count the registered ack/error pulses and saturate at all-ones.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      ack_cnt_d[i] = ack_cnt_q[i];
      if (req_ack_q[i] && ack_cnt_q[i] != '1) ack_cnt_d[i] = ack_cnt_q[i] + STAT_W'(1);
    end
    err_cnt_d = err_cnt_q;
    if (gnt_err_q && err_cnt_q != '1) err_cnt_d = err_cnt_q + STAT_W'(1);
    stat_cnt_d = ack_cnt_q[stat_sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) ack_cnt_q[i] <= '0;
      err_cnt_q  <= '0;
      stat_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) ack_cnt_q[i] <= ack_cnt_d[i];
      err_cnt_q  <= err_cnt_d;
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign stat_cnt = stat_cnt_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_grant_xfer_mux.sv
// Randomised and directed bench for grant_xfer_mux with a transaction-level reference model.
module tb_grant_xfer_mux;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  typedef struct {
    int         tag;
    logic       valid;
    logic [7:0] data;
    logic [1:0] src;
    logic [3:0] ack;
    logic       busy;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model: an outstanding word waits for the sink, then one ack cycle follows.
  logic       have_word = 1'b0;
  logic       ack_pending = 1'b0;
  logic [7:0] last_data = '0;
  logic [1:0] last_src = '0;

  grant_xfer_mux_if #(.NREQ(NREQ), .DW(DW)) bus ();

`ifdef GRANT_XFER_STATS_EN
  logic [1:0]  stat_sel = '0;
  logic [15:0] stat_cnt;
  logic [15:0] err_cnt;
  int          ack_count[NREQ];
  int          err_count = 0;
`endif

  grant_xfer_mux #(.NREQ(NREQ), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef GRANT_XFER_STATS_EN
    ,
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt),
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  // Drives one cycle of inputs and pushes what the outputs must be after the next edge.
  task automatic applyStimulus(input logic r, input logic [3:0] g, input logic [31:0] d, input logic rdy);
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus.gnt      = g;
    bus.req_data = d;
    bus.m_ready  = rdy;
    e.ack = '0;
    e.err = 1'b0;
    if (r) begin
      have_word   = 1'b0;
      ack_pending = 1'b0;
      last_data   = '0;
      last_src    = '0;
`ifdef GRANT_XFER_STATS_EN
      for (int i = 0; i < NREQ; i++) ack_count[i] = 0;
      err_count = 0;
`endif
    end else if (ack_pending) begin
      ack_pending = 1'b0;
    end else if (have_word) begin
      if (rdy) begin
        have_word   = 1'b0;
        ack_pending = 1'b1;
        e.ack[last_src] = 1'b1;
`ifdef GRANT_XFER_STATS_EN
        ack_count[last_src]++;
`endif
      end
    end else if ($countones(g) == 1) begin
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) begin
          last_src  = 2'(i);
          last_data = d[i*DW +: DW];
        end
      end
      have_word = 1'b1;
    end else if ($countones(g) > 1) begin
      e.err = 1'b1;
`ifdef GRANT_XFER_STATS_EN
      err_count++;
`endif
    end
    e.tag   = edge_cnt + 1;
    e.valid = have_word;
    e.busy  = have_word || ack_pending;
    e.data  = last_data;
    e.src   = last_src;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the expectation tagged for the edge just taken and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].tag == edge_cnt) begin
        e = exp_q.pop_front();
        checkOutput("m_valid", 32'(bus.m_valid), 32'(e.valid));
        checkOutput("m_data",  32'(bus.m_data),  32'(e.data));
        checkOutput("m_src",   32'(bus.m_src),   32'(e.src));
        checkOutput("req_ack", 32'(bus.req_ack), 32'(e.ack));
        checkOutput("busy",    32'(bus.busy),    32'(e.busy));
        checkOutput("gnt_err", 32'(bus.gnt_err), 32'(e.err));
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  g;
    bus.gnt      = '0;
    bus.req_data = '0;
    bus.m_ready  = 1'b0;

    $display("[TB] reset");
    applyStimulus(1, 4'b0000, 32'h0, 0);
    applyStimulus(1, 4'b0000, 32'h0, 0);

    $display("[TB] single transfer from port 2");
    d = $urandom;
    d[23:16] = 8'hA5;
    applyStimulus(0, 4'b0100, d, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0000, $urandom, 1);

    $display("[TB] stalled sink with grant toggling");
    d = $urandom;
    d[7:0] = 8'h3C;
    applyStimulus(0, 4'b0001, d, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 4'($urandom), $urandom, 0);
    applyStimulus(0, 4'b0010, $urandom, 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 4'b0000, $urandom, 0);

    $display("[TB] multi-hot grant");
    applyStimulus(0, 4'b0011, $urandom, 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 4'b0000, $urandom, 1);

    $display("[TB] reset during SEND");
    applyStimulus(0, 4'b0010, $urandom, 0);
    applyStimulus(0, 4'b0000, $urandom, 0);
    applyStimulus(1, 4'b0100, $urandom, 1);
    applyStimulus(0, 4'b0001, $urandom, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0000, $urandom, 1);

    $display("[TB] round-robin back-to-back");
    for (int p = 0; p < NREQ; p++) begin
      g = 4'b0001 << p;
      for (int c = 0; c < 3; c++) applyStimulus(0, g, $urandom, 1);
    end

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    g = 4'b0000;
        2, 3:    g = 4'b0001 << $urandom_range(0, 3);
        default: g = 4'($urandom);
      endcase
      applyStimulus(($urandom_range(0, 99) == 0), g, $urandom, ($urandom_range(0, 9) < 6));
    end

    for (int i = 0; i < 4; i++) applyStimulus(0, 4'b0000, $urandom, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'd0);

`ifdef GRANT_XFER_STATS_EN
    for (int i = 0; i < NREQ; i++) begin
      @(negedge clk);
      stat_sel = 2'(i);
      @(negedge clk);
      checkOutput("stat_cnt", 32'(stat_cnt), 32'(ack_count[i]));
    end
    checkOutput("err_cnt", 32'(err_cnt), 32'(err_count));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
